// File: rtl/pipe2_skid.sv
// pipe2_skid: decode->execute stage register with valid/ready handshake, sync flush
// and optional two-entry skid buffer (define PIPE2_SKID_EN to enable the skid).
module pipe2_skid #(
    parameter int unsigned DW  = 128,
    parameter int unsigned AW  = 21,
    parameter int unsigned BEW = DW / 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic [0:4]     aluop_in,
    output logic [0:4]     aluop_out,
    input  logic [0:2]     ppp_in,
    output logic [0:2]     ppp_out,
    input  logic [0:1]     ww_in,
    output logic [0:1]     ww_out,
    input  logic [0:1]     memop_in,
    output logic           memWrEn_out,
    output logic           memEn_out,
    input  logic [0:AW-1]  memAddr_in,
    output logic [0:AW-1]  memAddr_out,
    input  logic [0:BEW-1] wbyteen_in,
    output logic [0:BEW-1] wbyteen_out,
    input  logic           regwren_in,
    output logic           regwren_out,
    input  logic [0:4]     rwraddrd_in,
    output logic [0:4]     rwraddrd_out,
    input  logic           reginmuxop_in,
    output logic           reginmuxop_out,
    input  logic [0:DW-1]  rd1data_in,
    output logic [0:DW-1]  rd1data_out,
    input  logic [0:DW-1]  rd2data_in,
    output logic [0:DW-1]  rd2data_out
);

    localparam int unsigned PW = 5 + 3 + 2 + 2 + AW + BEW + 1 + 5 + 1 + 2 * DW;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q;
    logic          load_main;
    logic          mem_en_dec;
    logic          mem_wr_dec;

    // memop 1x enables memory, 11 is a write; 01 is reserved and decodes to idle
    assign mem_en_dec = memop_in[0];
    assign mem_wr_dec = memop_in[0] & memop_in[1];

    assign in_pl = {aluop_in, ppp_in, ww_in, mem_en_dec, mem_wr_dec, memAddr_in,
                    wbyteen_in, regwren_in, rwraddrd_in, reginmuxop_in,
                    rd1data_in, rd2data_in};

    assign {aluop_out, ppp_out, ww_out, memEn_out, memWrEn_out, memAddr_out,
            wbyteen_out, regwren_out, rwraddrd_out, reginmuxop_out,
            rd1data_out, rd2data_out} = main_q;

    assign out_valid = (state_q != ST_EMPTY);

`ifdef PIPE2_SKID_EN
    logic [PW-1:0] skid_q;
    logic          load_skid;
    logic          take_skid;

    assign in_ready = (state_q != ST_TWO);

    // next-state and load controls; flush overrides everything
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        take_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_valid && out_ready) begin
                    load_main = 1'b1;
                end else if (in_valid) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    state_d   = ST_ONE;
                    take_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            take_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_pl;
            end else if (take_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pl;
            end
        end
    end
`else
    assign in_ready = out_ready | ~out_valid;

    // single-entry variant: accept only when the held entry leaves this cycle
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_valid && out_ready) begin
                    load_main = 1'b1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= in_pl;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_pipe2_skid.sv
// Bench for pipe2_skid: FIFO-queue reference model checked every cycle plus directed literal checks.
module tb_pipe2_skid;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 16;
    localparam int unsigned BEW = 8;
`ifdef PIPE2_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [0:4] aluop_in, aluop_out;
    logic [0:2] ppp_in, ppp_out;
    logic [0:1] ww_in, ww_out, memop_in;
    logic memWrEn_out, memEn_out;
    logic [0:AW-1] memAddr_in, memAddr_out;
    logic [0:BEW-1] wbyteen_in, wbyteen_out;
    logic regwren_in, regwren_out, reginmuxop_in, reginmuxop_out;
    logic [0:4] rwraddrd_in, rwraddrd_out;
    logic [0:DW-1] rd1data_in, rd1data_out, rd2data_in, rd2data_out;

    int total = 0;
    int bad = 0;

    pipe2_skid #(.DW(DW), .AW(AW), .BEW(BEW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop_in(aluop_in), .aluop_out(aluop_out),
        .ppp_in(ppp_in), .ppp_out(ppp_out),
        .ww_in(ww_in), .ww_out(ww_out),
        .memop_in(memop_in), .memWrEn_out(memWrEn_out), .memEn_out(memEn_out),
        .memAddr_in(memAddr_in), .memAddr_out(memAddr_out),
        .wbyteen_in(wbyteen_in), .wbyteen_out(wbyteen_out),
        .regwren_in(regwren_in), .regwren_out(regwren_out),
        .rwraddrd_in(rwraddrd_in), .rwraddrd_out(rwraddrd_out),
        .reginmuxop_in(reginmuxop_in), .reginmuxop_out(reginmuxop_out),
        .rd1data_in(rd1data_in), .rd1data_out(rd1data_out),
        .rd2data_in(rd2data_in), .rd2data_out(rd2data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [42:0]  ctrl;
        logic [127:0] data;
    } ent_t;

    ent_t mq[$];
    ent_t cur;
    bit   m_valid, m_rdy, m_xfer, m_acc;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] decode(input logic [1:0] mop);
        case (mop)
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [42:0] dut_ctrl();
        return {aluop_out, ppp_out, ww_out, memEn_out, memWrEn_out, memAddr_out,
                wbyteen_out, regwren_out, rwraddrd_out, reginmuxop_out};
    endfunction

    // reference model: queue of entries, compared then advanced on each falling edge
    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            check("rst_out_valid", 128'(out_valid), 128'(0));
            check("rst_in_ready", 128'(in_ready), 128'(1));
            check("rst_zero", 128'(|{dut_ctrl(), rd1data_out, rd2data_out}), 128'(0));
        end else begin
            m_valid = (mq.size() != 0);
            m_rdy   = SKID ? (mq.size() < 2) : (out_ready || mq.size() == 0);
            check("out_valid", 128'(out_valid), 128'(m_valid));
            check("in_ready", 128'(in_ready), 128'(m_rdy));
            if (m_valid) begin
                check("ctrl", 128'(dut_ctrl()), 128'(mq[0].ctrl));
                check("data", {rd1data_out, rd2data_out}, mq[0].data);
            end
            cur.ctrl = {aluop_in, ppp_in, ww_in, decode(memop_in), memAddr_in,
                        wbyteen_in, regwren_in, rwraddrd_in, reginmuxop_in};
            cur.data = {rd1data_in, rd2data_in};
            m_xfer = m_valid && out_ready;
            m_acc  = in_valid && m_rdy;
            if (m_xfer) void'(mq.pop_front());
            if (m_acc) mq.push_back(cur);
            if (flush) mq.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input logic [63:0] d, input logic [1:0] mop);
        in_valid      = v;
        rd1data_in    = d;
        rd2data_in    = ~d ^ 64'h1234_5678_9abc_def0;
        aluop_in      = 5'(d * 3 + 1);
        ppp_in        = 3'(d + 2);
        ww_in         = 2'(d);
        memop_in      = mop;
        memAddr_in    = 16'(d * 257 + 5);
        wbyteen_in    = 8'(d ^ 64'hA5);
        regwren_in    = d[0];
        rwraddrd_in   = 5'(d + 7);
        reginmuxop_in = d[1];
    endtask

    logic [1:0] dec_mop[4];
    logic [1:0] dec_exp[4];
    logic [15:0] pat_v, pat_r;

    initial begin
        dec_mop = '{2'b11, 2'b10, 2'b00, 2'b01};
        dec_exp = '{2'b11, 2'b10, 2'b00, 2'b00};
        pat_v   = 16'b1011_0111_0110_1101;
        pat_r   = 16'b0110_1100_1011_0011;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        put(1'b0, 64'd0, 2'b00);
        step();
        check("init_out_valid", 128'(out_valid), 128'(0));
        check("init_in_ready", 128'(in_ready), 128'(1));
        reset = 1'b1;
        step();

        // streaming: eight back-to-back entries, latency one
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 64'(i), 2'b00);
            step();
            check("stream_valid", 128'(out_valid), 128'(1));
            check("stream_data", 128'(rd1data_out), 128'(i));
        end
        put(1'b0, 64'd0, 2'b00);
        step();
        check("stream_drain", 128'(out_valid), 128'(0));

        // memop decode
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 64'(16 + i), dec_mop[i]);
            step();
            check("decode", 128'({memEn_out, memWrEn_out}), 128'(dec_exp[i]));
        end
        put(1'b0, 64'd0, 2'b00);
        step();

        // three-cycle stall with A then B
        out_ready = 1'b0;
        put(1'b1, 64'hA0A0, 2'b10);
        step();
        check("stall_a", 128'(rd1data_out), 128'(64'hA0A0));
        put(1'b1, 64'hB0B0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_a", 128'(rd1data_out), 128'(64'hA0A0));
            check("stall_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        if (SKID) in_valid = 1'b0;
        step();
        check("release_b_valid", 128'(out_valid), 128'(1));
        check("release_b", 128'(rd1data_out), 128'(64'hB0B0));
        put(1'b0, 64'd0, 2'b00);
        step();
        check("release_empty", 128'(out_valid), 128'(0));

        // flush with held entries and a new input in the same cycle
        out_ready = 1'b0;
        put(1'b1, 64'hC1, 2'b10);
        step();
        put(1'b1, 64'hC2, 2'b10);
        step();
        flush = 1'b1; out_ready = 1'b1;
        put(1'b1, 64'hC3, 2'b11);
        step();
        flush = 1'b0;
        put(1'b0, 64'd0, 2'b00);
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        step();
        check("flush_stays_empty", 128'(out_valid), 128'(0));

        // mixed valid/ready pattern, checked by the model each cycle
        for (int i = 0; i < 16; i++) begin
            put(pat_v[i], 64'(100 + i), 2'(i));
            out_ready = pat_r[i];
            step();
        end
        put(1'b0, 64'd0, 2'b00);
        out_ready = 1'b1;
        step(); step(); step();
        check("mix_drained", 128'(out_valid), 128'(0));

        // asynchronous reset with entries held
        out_ready = 1'b0;
        put(1'b1, 64'hD1, 2'b11);
        step();
        put(1'b1, 64'hD2, 2'b10);
        step();
        #2 reset = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_in_ready", 128'(in_ready), 128'(1));
        check("arst_zero", 128'(|{dut_ctrl(), rd1data_out, rd2data_out}), 128'(0));
        put(1'b0, 64'd0, 2'b00);
        out_ready = 1'b1;
        step();
        reset = 1'b1;
        put(1'b1, 64'hE1, 2'b10);
        step();
        check("post_rst_accept", 128'(rd1data_out), 128'(64'hE1));
        put(1'b0, 64'd0, 2'b00);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
